multisim_pull_arbiter: RTL and testbench

- Shares one multisim pull-channel output among NUM_REQ consumers. The upstream side is the server pull block's data_vld/data_rdy/data.
- Grants the channel to one requester at a time, round-robin, for a bounded burst of beats.
- Each accepted beat is registered in a one-entry output buffer tagged with its destination.
- Sits between a single pull server instance and several testbench/emulation consumers, so one DPI channel can feed many agents.

---
 rtl/multisim_pull_arbiter.sv | 163 ++++++++++++++++
 tb/tb_multisim_pull_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multisim_pull_arbiter.sv
// Round-robin arbiter that fans one pull-channel stream out to NUM_REQ consumers through a one-beat buffer.
// Optional per-requester transfer counters are enabled with `define MULTISIM_PULL_ARB_STATS_EN.
module multisim_pull_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_vld,
  output logic                  up_rdy,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    dn_vld,
  input  logic [NUM_REQ-1:0]    dn_rdy,
  output logic [DATA_WIDTH-1:0] dn_data
`ifdef MULTISIM_PULL_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [NUM_REQ*32-1:0] beat_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (BURST_LEN == 0) ? 1 : $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                  state_q,    state_d;
  logic [NUM_REQ-1:0]      grant_q,    grant_d;
  logic [IDX_W-1:0]        gidx_q,     gidx_d;
  logic [IDX_W-1:0]        rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    buf_vld_q,  buf_vld_d;
  logic [IDX_W-1:0]        buf_dst_q,  buf_dst_d;
  logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             accept;
  logic             drain;
  logic             last_beat;
  logic             req_gone;

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign drain     = buf_vld_q && dn_rdy[buf_dst_q];
  assign up_rdy    = (state_q == BURST) && (!buf_vld_q || dn_rdy[buf_dst_q]);
  assign accept    = up_vld && up_rdy;
  assign last_beat = (BURST_LEN != 0) && accept && (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign req_gone  = !req[gidx_q] && !accept;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    buf_vld_d  = buf_vld_q;
    buf_dst_d  = buf_dst_q;
    buf_data_d = buf_data_q;

    if (drain) buf_vld_d = 1'b0;
    // A load in the drain cycle wins, giving back-to-back beats.
    if (accept) begin
      buf_vld_d  = 1'b1;
      buf_dst_d  = gidx_q;
      buf_data_d = up_data;
      if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BURST;
          gidx_d     = pick_idx;
          grant_d    = NUM_REQ'(1) << pick_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (last_beat || req_gone) begin
          state_d  = IDLE;
          rr_ptr_d = gidx_q;
          grant_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      buf_vld_q  <= 1'b0;
      buf_dst_q  <= '0;
      // NOTE: the data register is reset too because dn_data is visible and must read zero after reset.
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      buf_vld_q  <= buf_vld_d;
      buf_dst_q  <= buf_dst_d;
      buf_data_q <= buf_data_d;
    end
  end

  always_comb begin
    dn_vld = '0;
    if (buf_vld_q) dn_vld[buf_dst_q] = 1'b1;
  end

  assign grant   = grant_q;
  assign dn_data = buf_data_q;

`ifdef MULTISIM_PULL_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (dn_vld[i] && dn_rdy[i]) stat_d[i] = stat_q[i] + 32'd1;
    end
    if (stats_clr) stat_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign beat_count = stat_q;
`endif

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_dn_vld_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dn_vld));
  a_idle_no_rdy: assert property (@(posedge clk) disable iff (!rst_n) (state_q == IDLE) |-> !up_rdy);
`endif

endmodule

// File: tb/tb_multisim_pull_arbiter.sv
// Directed self-checking bench for multisim_pull_arbiter with default parameters (4 requesters, burst 4).
module tb_multisim_pull_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_vld;
  logic          up_rdy;
  logic [DW-1:0] up_data;
  logic [NR-1:0] req;
  logic [NR-1:0] grant;
  logic [NR-1:0] dn_vld;
  logic [NR-1:0] dn_rdy;
  logic [DW-1:0] dn_data;
`ifdef MULTISIM_PULL_ARB_STATS_EN
  logic             stats_clr;
  logic [NR*32-1:0] beat_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multisim_pull_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up_vld  (up_vld),
    .up_rdy  (up_rdy),
    .up_data (up_data),
    .req     (req),
    .grant   (grant),
    .dn_vld  (dn_vld),
    .dn_rdy  (dn_rdy),
    .dn_data (dn_data)
`ifdef MULTISIM_PULL_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .beat_count (beat_count)
`endif
  );

  // Scenario 1 expectations, one entry per clock edge after reset release.
  logic [3:0] s1_g   [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
  logic [3:0] s1_dv  [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4};
  logic       s1_rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] s1_d   [10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Advances one clock; the source presents the next sequential word after each accepted beat.
  task automatic tick();
    logic acc;
    #1;
    acc = up_vld && up_rdy;
    @(posedge clk);
    #1;
    if (acc) up_data = up_data + 64'd1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    up_vld  = 1'b0;
    up_data = '0;
    dn_rdy  = '1;
`ifdef MULTISIM_PULL_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_grant",   64'(grant),   64'h0);
    check("rst_dn_vld",  64'(dn_vld),  64'h0);
    check("rst_up_rdy",  64'(up_rdy),  64'h0);
    check("rst_dn_data", dn_data,      64'h0);

    // Two requesters alternate bursts of four.
    rst_n   = 1'b1;
    req     = 4'b0101;
    up_vld  = 1'b1;
    up_data = 64'h10;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("s1_grant[%0d]", c),   64'(grant),  64'(s1_g[c]));
      check($sformatf("s1_dn_vld[%0d]", c),  64'(dn_vld), 64'(s1_dv[c]));
      check($sformatf("s1_up_rdy[%0d]", c),  64'(up_rdy), 64'(s1_rdy[c]));
      check($sformatf("s1_dn_data[%0d]", c), dn_data,     64'(s1_d[c]));
    end
    req    = '0;
    up_vld = 1'b0;
    tick();
    check("s1_idle_grant",  64'(grant),  64'h0);
    check("s1_idle_dn_vld", 64'(dn_vld), 64'h0);

    // All four request continuously: 8 bursts, five cycles each.
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    req     = 4'hF;
    up_vld  = 1'b1;
    up_data = 64'h100;
    for (int k = 0; k < 40; k++) begin
      int phase;
      int grp;
      logic [3:0] eg;
      logic [3:0] edv;
      tick();
      phase = k % 5;
      grp   = k / 5;
      eg    = (phase < 4)  ? 4'(1 << (grp % 4)) : 4'h0;
      edv   = (phase == 0) ? 4'h0 : 4'(1 << (grp % 4));
      check($sformatf("s2_grant[%0d]", k),  64'(grant),  64'(eg));
      check($sformatf("s2_up_rdy[%0d]", k), 64'(up_rdy), 64'(phase < 4));
      check($sformatf("s2_dn_vld[%0d]", k), 64'(dn_vld), 64'(edv));
      if (phase != 0)
        check($sformatf("s2_dn_data[%0d]", k), dn_data, 64'(32'h100 + grp * 4 + phase - 1));
    end
    req    = '0;
    up_vld = 1'b0;
    tick();
    check("s2_end_grant",  64'(grant),  64'h0);
    check("s2_end_dn_vld", 64'(dn_vld), 64'h0);
`ifdef MULTISIM_PULL_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      check($sformatf("s2_beat_count[%0d]", i), 64'(beat_count[32*i +: 32]), 64'd8);
`endif

    // Backpressure on requester 1 while its beat is buffered.
    req     = 4'b0010;
    up_vld  = 1'b1;
    dn_rdy  = 4'b1101;
    up_data = 64'h200;
    tick();
    check("s3_grant",  64'(grant),  64'h2);
    check("s3_up_rdy", 64'(up_rdy), 64'h1);
    tick();
    check("s3_dn_vld",  64'(dn_vld),  64'h2);
    check("s3_dn_data", dn_data,      64'h200);
    check("s3_stall_rdy", 64'(up_rdy), 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s3_hold_dn_vld[%0d]", i),  64'(dn_vld), 64'h2);
      check($sformatf("s3_hold_dn_data[%0d]", i), dn_data,     64'h200);
      check($sformatf("s3_hold_up_rdy[%0d]", i),  64'(up_rdy), 64'h0);
      check($sformatf("s3_hold_grant[%0d]", i),   64'(grant),  64'h2);
    end
    dn_rdy = 4'b1111;
`ifdef MULTISIM_PULL_ARB_STATS_EN
    stats_clr = 1'b1;
`endif
    #1;
    check("s3_release_rdy", 64'(up_rdy), 64'h1);
    tick();
    check("s3_reload_dn_vld",  64'(dn_vld), 64'h2);
    check("s3_reload_dn_data", dn_data,     64'h201);
`ifdef MULTISIM_PULL_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      check($sformatf("s3_clr_beat_count[%0d]", i), 64'(beat_count[32*i +: 32]), 64'd0);
    stats_clr = 1'b0;
`endif
    req    = '0;
    up_vld = 1'b0;
    tick();
    check("s3_exit_grant",  64'(grant),  64'h0);
    check("s3_exit_dn_vld", 64'(dn_vld), 64'h0);
`ifdef MULTISIM_PULL_ARB_STATS_EN
    check("s3_post_clr_count1", 64'(beat_count[63:32]), 64'd1);
    check("s3_post_clr_count0", 64'(beat_count[31:0]),  64'd0);
`endif

    // Requester 2 drops its request after two beats.
    req     = 4'b1100;
    up_vld  = 1'b1;
    up_data = 64'h300;
    tick();
    check("s4_grant2", 64'(grant), 64'h4);
    tick();
    check("s4_beat0_dn_vld",  64'(dn_vld), 64'h4);
    check("s4_beat0_dn_data", dn_data,     64'h300);
    tick();
    check("s4_beat1_dn_vld",  64'(dn_vld), 64'h4);
    check("s4_beat1_dn_data", dn_data,     64'h301);
    req    = 4'b1000;
    up_vld = 1'b0;
    tick();
    check("s4_drop_grant",  64'(grant),  64'h0);
    check("s4_drop_dn_vld", 64'(dn_vld), 64'h0);
    check("s4_drop_up_rdy", 64'(up_rdy), 64'h0);
    up_vld = 1'b1;
    tick();
    check("s4_grant3", 64'(grant), 64'h8);
    tick();
    check("s4_next_dn_vld",  64'(dn_vld), 64'h8);
    check("s4_next_dn_data", dn_data,     64'h302);

    // Reset while a beat is buffered mid-burst.
    rst_n = 1'b0;
    tick();
    check("s5_rst_grant",   64'(grant),  64'h0);
    check("s5_rst_dn_vld",  64'(dn_vld), 64'h0);
    check("s5_rst_up_rdy",  64'(up_rdy), 64'h0);
    check("s5_rst_dn_data", dn_data,     64'h0);
    rst_n  = 1'b1;
    req    = 4'hF;
    up_vld = 1'b0;
    tick();
    check("s5_first_grant", 64'(grant), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
